sargantana_icache_repl_policy_unit: RTL and testbench

Parametrised successor to the icache replacement logic. Selects the victim way on refill:
- lowest-index invalid way if any way is invalid;
- otherwise the way chosen by a compile-time policy (LFSR random, global round-robin, or per-set tree-PLRU).
It also owns a hardware flush walker that clears every set's valid bits and replacement state. It sits between the icache controller and the tag/valid/data RAMs.

---
 rtl/sargantana_icache_repl_policy_unit_if.sv | 42 ++++
 rtl/sargantana_icache_repl_policy_unit.sv | 177 +++++++++++++++++
 tb/tb_sargantana_icache_repl_policy_unit.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sargantana_icache_repl_policy_unit_if.sv
// Controller-side bundle of the icache replacement unit: request strobes in, RAM enables and victim out.
// No flow control; every field is sampled or driven combinationally each cycle.
interface sargantana_icache_repl_policy_unit_if #(
  parameter int N_WAY = 4,
  parameter int N_SET = 64
);
  localparam int IDX_W = $clog2(N_SET);
  localparam int WAY_W = $clog2(N_WAY);

  logic             flush_i;
  logic             inval_i;
  logic             cache_rd_ena_i;
  logic             cache_wr_ena_i;
  logic             hit_i;
  logic [WAY_W-1:0] hit_way_i;
  logic             cmp_en_i;
  logic [IDX_W-1:0] cline_index_i;
  logic [N_WAY-1:0] way_valid_bits_i;
  logic [WAY_W-1:0] way_to_replace_o;
  logic [WAY_W-1:0] way_to_replace_q_o;
  logic             we_valid_o;
  logic             valid_wdata_o;
  logic [IDX_W-1:0] addr_valid_o;
  logic [N_WAY-1:0] tag_req_valid_o;
  logic [N_WAY-1:0] data_req_valid_o;
  logic             flush_busy_o;
  logic [31:0]      evict_cnt_o;

  modport master (
    output flush_i, inval_i, cache_rd_ena_i, cache_wr_ena_i, hit_i, hit_way_i,
           cmp_en_i, cline_index_i, way_valid_bits_i,
    input  way_to_replace_o, way_to_replace_q_o, we_valid_o, valid_wdata_o,
           addr_valid_o, tag_req_valid_o, data_req_valid_o, flush_busy_o, evict_cnt_o
  );

  modport slave (
    input  flush_i, inval_i, cache_rd_ena_i, cache_wr_ena_i, hit_i, hit_way_i,
           cmp_en_i, cline_index_i, way_valid_bits_i,
    output way_to_replace_o, way_to_replace_q_o, we_valid_o, valid_wdata_o,
           addr_valid_o, tag_req_valid_o, data_req_valid_o, flush_busy_o, evict_cnt_o
  );
endinterface

// File: rtl/sargantana_icache_repl_policy_unit.sv
// Icache victim selection (invalid-first, then LFSR/round-robin/tree-PLRU) plus N_SET-cycle flush walker.
// Victim is combinational, registered copy on cmp_en_i; no backpressure. ICACHE_REPL_EVICT_CNT_EN adds an eviction counter.
module sargantana_icache_repl_policy_unit #(
  parameter  int N_WAY  = 4,
  parameter  int N_SET  = 64,
  parameter  int POLICY = 2,
  localparam int IDX_W  = $clog2(N_SET),
  localparam int WAY_W  = $clog2(N_WAY)
) (
  input logic                                clk_i,
  input logic                                rstn_i,
  sargantana_icache_repl_policy_unit_if.slave bus
);

  typedef enum logic {IDLE, FLUSH} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [WAY_W-1:0] victim_q, victim_d;
  logic [WAY_W-1:0] rr_q, rr_d;
  logic [7:0]       lfsr_q, lfsr_d;
  logic [N_WAY-2:0] plru_q [N_SET];
  logic [N_WAY-2:0] plru_d [N_SET];

  logic             all_valid;
  logic             idle_act;
  logic [WAY_W-1:0] invalid_way;
  logic [WAY_W-1:0] policy_way;
  logic [WAY_W-1:0] victim;
  logic [N_WAY-1:0] victim_q_onehot;

  // Tree walk: a 0 node sends the victim search into the lower half of its subtree.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [N_WAY-2:0] tree);
    logic [WAY_W-1:0] w;
    int               node;
    w    = '0;
    node = 0;
    for (int l = 0; l < WAY_W; l++) begin
      w    = (w << 1) | WAY_W'(tree[node]);
      node = 2 * node + 1 + int'(tree[node]);
    end
    return w;
  endfunction

  function automatic logic [N_WAY-2:0] plru_touch(input logic [N_WAY-2:0] tree,
                                                  input logic [WAY_W-1:0] way);
    logic [N_WAY-2:0] r;
    int               node;
    logic             b;
    r    = tree;
    node = 0;
    for (int l = WAY_W - 1; l >= 0; l--) begin
      b       = way[l];
      r[node] = ~b;
      node    = 2 * node + 1 + int'(b);
    end
    return r;
  endfunction

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {1'b0, l[7:1]} ^ (l[0] ? 8'hB8 : 8'h00);
  endfunction

  assign all_valid = &bus.way_valid_bits_i;
  assign idle_act  = (state_q == IDLE) && !bus.flush_i;

  always_comb begin
    invalid_way = '0;
    for (int i = N_WAY - 1; i >= 0; i--) begin
      if (!bus.way_valid_bits_i[i]) invalid_way = WAY_W'(i);
    end
    if (POLICY == 0)      policy_way = lfsr_q[WAY_W-1:0];
    else if (POLICY == 1) policy_way = rr_q;
    else                  policy_way = plru_victim(plru_q[bus.cline_index_i]);
    victim = all_valid ? policy_way : invalid_way;
  end

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    victim_d    = victim_q;
    rr_d        = rr_q;
    lfsr_d      = lfsr_q;
    plru_d      = plru_q;
    case (state_q)
      IDLE: begin
        if (bus.flush_i) begin
          state_d = FLUSH;
        end else begin
          if (bus.cmp_en_i) victim_d = victim;
          if (bus.cache_wr_ena_i && all_valid) begin
            rr_d   = rr_q + 1'b1;
            lfsr_d = lfsr_step(lfsr_q);
          end
          // A refill touches the way being written, overriding a same-cycle hit.
          if (bus.cache_wr_ena_i)
            plru_d[bus.cline_index_i] = plru_touch(plru_q[bus.cline_index_i], victim_q);
          else if (bus.cache_rd_ena_i && bus.hit_i)
            plru_d[bus.cline_index_i] = plru_touch(plru_q[bus.cline_index_i], bus.hit_way_i);
        end
      end
      FLUSH: begin
        plru_d[flush_cnt_q] = '0;
        if (flush_cnt_q == IDX_W'(N_SET - 1)) begin
          state_d     = IDLE;
          flush_cnt_d = '0;
          rr_d        = '0;
        end else begin
          flush_cnt_d = flush_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    victim_q_onehot = {{(N_WAY-1){1'b0}}, 1'b1} << victim_q;
    if (state_q == FLUSH) begin
      bus.addr_valid_o     = flush_cnt_q;
      bus.we_valid_o       = 1'b1;
      bus.valid_wdata_o    = 1'b0;
      bus.tag_req_valid_o  = '1;
      bus.data_req_valid_o = '0;
    end else begin
      bus.addr_valid_o     = bus.cline_index_i;
      bus.tag_req_valid_o  = bus.cache_rd_ena_i ? '1 : victim_q_onehot;
      bus.data_req_valid_o = bus.cache_rd_ena_i ? '1 :
                             (bus.cache_wr_ena_i ? victim_q_onehot : '0);
      bus.we_valid_o       = !bus.flush_i && (bus.cache_wr_ena_i || bus.inval_i);
      bus.valid_wdata_o    = !bus.flush_i && bus.cache_wr_ena_i;
    end
  end

  assign bus.flush_busy_o       = (state_q == FLUSH);
  assign bus.way_to_replace_o   = victim;
  assign bus.way_to_replace_q_o = victim_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= IDLE;
      flush_cnt_q <= '0;
      victim_q    <= '0;
      rr_q        <= '0;
      lfsr_q      <= 8'd1;
      for (int s = 0; s < N_SET; s++) plru_q[s] <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      victim_q    <= victim_d;
      rr_q        <= rr_d;
      lfsr_q      <= lfsr_d;
      for (int s = 0; s < N_SET; s++) plru_q[s] <= plru_d[s];
    end
  end

`ifdef ICACHE_REPL_EVICT_CNT_EN
  logic [31:0] evict_cnt_q, evict_cnt_d;

  always_comb begin
    evict_cnt_d = evict_cnt_q;
    if (idle_act && bus.cache_wr_ena_i && all_valid && (evict_cnt_q != 32'hFFFF_FFFF))
      evict_cnt_d = evict_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) evict_cnt_q <= '0;
    else         evict_cnt_q <= evict_cnt_d;
  end

  assign bus.evict_cnt_o = evict_cnt_q;
`else
  logic unused_idle_act;
  assign unused_idle_act = idle_act;
  assign bus.evict_cnt_o = '0;
`endif

endmodule

// File: tb/tb_sargantana_icache_repl_policy_unit.sv
// Bench for the icache replacement unit: per-cycle model comparison plus directed literal checks.
module tb_sargantana_icache_repl_policy_unit;
  localparam int N_WAY = 4;
  localparam int N_SET = 64;

  bit clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  sargantana_icache_repl_policy_unit_if #(.N_WAY(N_WAY), .N_SET(N_SET)) ifc ();
  sargantana_icache_repl_policy_unit_if #(.N_WAY(N_WAY), .N_SET(N_SET)) rif ();

  sargantana_icache_repl_policy_unit #(.N_WAY(N_WAY), .N_SET(N_SET), .POLICY(2)) dut (
    .clk_i(clk), .rstn_i(rstn), .bus(ifc));
  sargantana_icache_repl_policy_unit #(.N_WAY(N_WAY), .N_SET(N_SET), .POLICY(1)) dut_rr (
    .clk_i(clk), .rstn_i(rstn), .bus(rif));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Model: each PLRU node remembers which half of its range holds the next victim (1 = upper).
  int     m_tree [N_SET][N_WAY];
  bit     m_flush;
  int     m_cnt, m_q, m_rr, m_lfsr;
  longint m_evict;

  function automatic int m_plru_victim(input int s);
    int lo = 0, size = N_WAY, node = 0;
    while (size > 1) begin
      size = size / 2;
      if (m_tree[s][node] != 0) begin lo += size; node = 2 * node + 2; end
      else node = 2 * node + 1;
    end
    return lo;
  endfunction

  task automatic m_touch(input int s, input int w);
    int lo = 0, size = N_WAY, node = 0;
    while (size > 1) begin
      size = size / 2;
      if (w >= lo + size) begin m_tree[s][node] = 0; lo += size; node = 2 * node + 2; end
      else begin m_tree[s][node] = 1; node = 2 * node + 1; end
    end
  endtask

  task automatic m_reset();
    foreach (m_tree[s, n]) m_tree[s][n] = 0;
    m_flush = 0; m_cnt = 0; m_q = 0; m_rr = 0; m_lfsr = 1; m_evict = 0;
  endtask

  int e_victim, e_addr, e_tag, e_data, e_we, e_wd, e_ev, idx, q_old;
  bit allv;

  always @(negedge clk) begin
    if (!rstn) m_reset();
    idx  = int'(ifc.cline_index_i);
    allv = (ifc.way_valid_bits_i == 4'hF);
    e_victim = 0;
    if (!allv) begin
      for (int i = N_WAY - 1; i >= 0; i--) if (!ifc.way_valid_bits_i[i]) e_victim = i;
    end else e_victim = m_plru_victim(idx);
    if (m_flush) begin
      e_addr = m_cnt; e_we = 1; e_wd = 0; e_tag = 'hF; e_data = 0;
    end else begin
      e_addr = idx;
      e_tag  = ifc.cache_rd_ena_i ? 'hF : (1 << m_q);
      e_data = ifc.cache_rd_ena_i ? 'hF : (ifc.cache_wr_ena_i ? (1 << m_q) : 0);
      e_we   = (!ifc.flush_i && (ifc.cache_wr_ena_i || ifc.inval_i)) ? 1 : 0;
      e_wd   = (!ifc.flush_i && ifc.cache_wr_ena_i) ? 1 : 0;
    end
`ifdef ICACHE_REPL_EVICT_CNT_EN
    e_ev = int'(m_evict);
`else
    e_ev = 0;
`endif
    chk("m_victim", 32'(ifc.way_to_replace_o), 32'(e_victim));
    chk("m_victim_q", 32'(ifc.way_to_replace_q_o), 32'(m_q));
    chk("m_addr", 32'(ifc.addr_valid_o), 32'(e_addr));
    chk("m_tag_req", 32'(ifc.tag_req_valid_o), 32'(e_tag));
    chk("m_data_req", 32'(ifc.data_req_valid_o), 32'(e_data));
    chk("m_we", 32'(ifc.we_valid_o), 32'(e_we));
    chk("m_wdata", 32'(ifc.valid_wdata_o), 32'(e_wd));
    chk("m_busy", 32'(ifc.flush_busy_o), 32'(m_flush));
    chk("m_evict", ifc.evict_cnt_o, 32'(e_ev));
    if (rstn) begin
      if (m_flush) begin
        for (int n = 0; n < N_WAY; n++) m_tree[m_cnt][n] = 0;
        if (m_cnt == N_SET - 1) begin m_flush = 0; m_cnt = 0; m_rr = 0; end
        else m_cnt++;
      end else if (ifc.flush_i) begin
        m_flush = 1;
      end else begin
        q_old = m_q;
        if (ifc.cmp_en_i) m_q = e_victim;
        if (ifc.cache_wr_ena_i && allv) begin
          m_rr = (m_rr + 1) % N_WAY;
          m_lfsr = (m_lfsr % 2 == 1) ? ((m_lfsr / 2) ^ 'hB8) : (m_lfsr / 2);
          if (m_evict < 64'hFFFF_FFFF) m_evict++;
        end
        if (ifc.cache_wr_ena_i) m_touch(idx, q_old);
        else if (ifc.cache_rd_ena_i && ifc.hit_i) m_touch(idx, int'(ifc.hit_way_i));
      end
    end
  end

  task automatic step(input bit rd, input bit wr, input bit inv, input bit hit, input int hw,
                      input bit cmp, input int ix, input logic [3:0] vb, input bit fl);
    @(posedge clk); #1;
    ifc.cache_rd_ena_i   = rd;
    ifc.cache_wr_ena_i   = wr;
    ifc.inval_i          = inv;
    ifc.hit_i            = hit;
    ifc.hit_way_i        = hw[1:0];
    ifc.cmp_en_i         = cmp;
    ifc.cline_index_i    = ix[5:0];
    ifc.way_valid_bits_i = vb;
    ifc.flush_i          = fl;
    @(negedge clk);
  endtask

  task automatic idle(input int ix, input logic [3:0] vb);
    step(0, 0, 0, 0, 0, 0, ix, vb, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int nb;
  int exp_ev;

  initial begin
    rstn = 1'b0;
    ifc.cache_rd_ena_i = 0; ifc.cache_wr_ena_i = 0; ifc.inval_i = 0; ifc.hit_i = 0;
    ifc.hit_way_i = '0; ifc.cmp_en_i = 0; ifc.cline_index_i = '0;
    ifc.way_valid_bits_i = '0; ifc.flush_i = 0;
    rif.cache_rd_ena_i = 0; rif.cache_wr_ena_i = 0; rif.inval_i = 0; rif.hit_i = 0;
    rif.hit_way_i = '0; rif.cmp_en_i = 0; rif.cline_index_i = '0;
    rif.way_valid_bits_i = '0; rif.flush_i = 0;
    repeat (2) @(negedge clk);
    chk("tc_rst_victim_q", 32'(ifc.way_to_replace_q_o), 0);
    chk("tc_rst_busy", 32'(ifc.flush_busy_o), 0);
    chk("tc_rst_we", 32'(ifc.we_valid_o), 0);
    chk("tc_rst_evict", ifc.evict_cnt_o, 0);
    @(posedge clk); #1; rstn = 1'b1;

    step(0, 0, 0, 0, 0, 1, 0, 4'b1011, 0);
    chk("tc_first_invalid", 32'(ifc.way_to_replace_o), 2);
    idle(0, 4'b1011);
    chk("tc_q_capture", 32'(ifc.way_to_replace_q_o), 2);

    step(0, 1, 0, 0, 0, 0, 10, 4'b1111, 0);
    chk("tc_refill_data_req", 32'(ifc.data_req_valid_o), 32'h4);
    chk("tc_refill_we", 32'(ifc.we_valid_o), 1);
    step(0, 1, 0, 0, 0, 0, 10, 4'b1111, 0);
    step(0, 1, 0, 0, 0, 0, 10, 4'b1111, 0);
    step(0, 1, 0, 0, 0, 0, 10, 4'b1011, 0);
    idle(10, 4'b1011);
`ifdef ICACHE_REPL_EVICT_CNT_EN
    exp_ev = 3;
`else
    exp_ev = 0;
`endif
    chk("tc_evict_cnt", ifc.evict_cnt_o, 32'(exp_ev));

    step(1, 0, 0, 1, 0, 0, 5, 4'b1111, 0);
    chk("tc_plru_s5_init", 32'(ifc.way_to_replace_o), 0);
    chk("tc_rd_tag_req", 32'(ifc.tag_req_valid_o), 32'hF);
    chk("tc_rd_data_req", 32'(ifc.data_req_valid_o), 32'hF);
    idle(5, 4'b1111);
    chk("tc_plru_after_hit0", 32'(ifc.way_to_replace_o), 2);
    step(1, 0, 0, 1, 2, 0, 5, 4'b1111, 0);
    idle(5, 4'b1111);
    chk("tc_plru_after_hit2", 32'(ifc.way_to_replace_o), 1);
    idle(6, 4'b1111);
    chk("tc_plru_s6_untouched", 32'(ifc.way_to_replace_o), 0);

    step(0, 0, 0, 0, 0, 1, 5, 4'b1111, 0);
    step(0, 1, 0, 0, 0, 0, 5, 4'b1111, 0);
    chk("tc_wr_data_req_way1", 32'(ifc.data_req_valid_o), 32'h2);
    idle(5, 4'b1111);
    chk("tc_plru_after_wr1", 32'(ifc.way_to_replace_o), 3);
    step(1, 1, 0, 1, 3, 0, 7, 4'b1111, 0);
    idle(7, 4'b1111);
    chk("tc_wr_beats_hit", 32'(ifc.way_to_replace_o), 2);

    step(0, 1, 1, 0, 0, 0, 9, 4'b1011, 0);
    chk("tc_wr_inval_we", 32'(ifc.we_valid_o), 1);
    chk("tc_wr_inval_wdata", 32'(ifc.valid_wdata_o), 1);
    step(0, 0, 1, 0, 0, 0, 9, 4'b1011, 0);
    chk("tc_inval_we", 32'(ifc.we_valid_o), 1);
    chk("tc_inval_wdata", 32'(ifc.valid_wdata_o), 0);

    step(0, 0, 0, 0, 0, 0, 0, 4'b1111, 1);
    nb = 0;
    for (int i = 0; i < N_SET; i++) begin
      step(1, 1, 1, 1, 1, 1, 33, 4'b1111, 1);
      nb += int'(ifc.flush_busy_o);
      chk("tc_flush_addr", 32'(ifc.addr_valid_o), 32'(i));
      chk("tc_flush_we", 32'(ifc.we_valid_o), 1);
      chk("tc_flush_wdata", 32'(ifc.valid_wdata_o), 0);
    end
    idle(5, 4'b1111);
    nb += int'(ifc.flush_busy_o);
    chk("tc_flush_len", 32'(nb), 64);
    chk("tc_flush_done_busy", 32'(ifc.flush_busy_o), 0);
    chk("tc_flush_plru_s5", 32'(ifc.way_to_replace_o), 0);
    chk("tc_flush_cmp_ignored", 32'(ifc.way_to_replace_q_o), 1);

    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      rif.way_valid_bits_i = 4'hF;
      rif.cache_wr_ena_i = 1'b1;
      @(negedge clk);
      chk("tc_rr_victim", 32'(rif.way_to_replace_o), 32'(k % N_WAY));
    end
    @(posedge clk); #1; rif.cache_wr_ena_i = 1'b0;

    step(0, 0, 0, 0, 0, 0, 0, 4'b1111, 1);
    repeat (10) idle(0, 4'b1111);
    @(posedge clk); #3; rstn = 1'b0; #1;
    chk("tc_rst_mid_flush_busy", 32'(ifc.flush_busy_o), 0);
    @(negedge clk);
    @(posedge clk); #1; rstn = 1'b1;
    step(0, 0, 0, 0, 0, 0, 0, 4'b1111, 1);
    idle(12, 4'b1111);
    chk("tc_restart_addr", 32'(ifc.addr_valid_o), 0);
    chk("tc_restart_busy", 32'(ifc.flush_busy_o), 1);
    repeat (N_SET + 2) idle(12, 4'b1111);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
